// File: rtl/descontador_timer.sv
// descontador_timer: programmable down-counter/timer.
// A loaded count is decremented by MINUS_VALUE once every PRESCALE qualified
// minus strobes while running. On expiry it either reloads and keeps running
// (auto_reload) or parks in DONE, emitting a one-cycle done pulse either way.
// All state updates happen on a single clock edge chosen by POS_EDGE.
module descontador_timer #(
  parameter int WIDTH       = 8,
  parameter int RST_VALUE   = 0,
  parameter int MINUS_VALUE = 1,
  parameter int PRESCALE    = 1,
  parameter int POS_EDGE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             minus,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  // Prescaler counts 0 .. PRESCALE-1; keep at least one bit so PRESCALE=1 is legal.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(MINUS_VALUE);
  localparam logic [WIDTH-1:0] RST_VAL    = WIDTH'(RST_VALUE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] value_reg,  value_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic [PW-1:0]    presc_reg,  presc_next;
  logic             done_reg,   done_next;
  logic             busy_reg,   busy_next;

  // Next-state logic; priority is load > start > pause > minus (rst is applied in the register stage).
  always_comb begin
    state_next  = state_reg;
    value_next  = value_reg;
    reload_next = reload_reg;
    presc_next  = presc_reg;
    done_next   = 1'b0;

    if (load) begin
      // Loading always aborts any countdown without a done pulse.
      value_next  = load_value;
      reload_next = load_value;
      presc_next  = '0;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            if (value_reg != '0) begin
              state_next = RUN;
              presc_next = '0;
            end else begin
              // Nothing to count: report completion immediately.
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end

        RUN: begin
          if (pause) begin
            // Freeze; the strobe in this cycle is dropped.
            state_next = PAUSE;
          end else if (minus) begin
            if (presc_reg < PRESC_LAST) begin
              presc_next = presc_reg + PW'(1);
            end else begin
              presc_next = '0;
              if (value_reg > STEP) begin
                value_next = value_reg - STEP;
              end else begin
                // Expiry: saturate at zero instead of wrapping.
                done_next = 1'b1;
                if (auto_reload && (reload_reg != '0)) begin
                  value_next = reload_reg;
                end else begin
                  value_next = '0;
                  state_next = DONE;
                end
              end
            end
          end
        end

        PAUSE: begin
          // Leaving pause only re-arms; counting resumes on the next strobe.
          if (!pause) begin
            state_next = RUN;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    busy_next = (state_next == RUN) || (state_next == PAUSE);
  end

  generate
    if (POS_EDGE != 0) begin : g_pos
      // State registers updated on the rising edge, synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg  <= IDLE;
          value_reg  <= RST_VAL;
          reload_reg <= RST_VAL;
          presc_reg  <= '0;
          done_reg   <= 1'b0;
          busy_reg   <= 1'b0;
        end else begin
          state_reg  <= state_next;
          value_reg  <= value_next;
          reload_reg <= reload_next;
          presc_reg  <= presc_next;
          done_reg   <= done_next;
          busy_reg   <= busy_next;
        end
      end
    end else begin : g_neg
      // State registers updated on the falling edge, synchronous reset.
      always_ff @(negedge clk) begin
        if (rst) begin
          state_reg  <= IDLE;
          value_reg  <= RST_VAL;
          reload_reg <= RST_VAL;
          presc_reg  <= '0;
          done_reg   <= 1'b0;
          busy_reg   <= 1'b0;
        end else begin
          state_reg  <= state_next;
          value_reg  <= value_next;
          reload_reg <= reload_next;
          presc_reg  <= presc_next;
          done_reg   <= done_next;
          busy_reg   <= busy_next;
        end
      end
    end
  endgenerate

  assign value = value_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign zero  = (value_reg == '0);

endmodule

// File: tb/tb_descontador_timer.sv
// Testbench for descontador_timer: three instances (default, MINUS=3/PRESCALE=2,
// negedge-clocked) driven from a vector table, expectations queued per vector.
module tb_descontador_timer;

  logic clk;
  logic       rst_a  [3];
  logic       load_a [3];
  logic [7:0] lv_a   [3];
  logic       start_a[3];
  logic       minus_a[3];
  logic       pause_a[3];
  logic       ar_a   [3];
  logic [7:0] value_a[3];
  logic       busy_a [3];
  logic       zero_a [3];
  logic       done_a [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         d;
    logic       rst, load;
    logic [7:0] lv;
    logic       start, minus, pause, ar;
    logic [7:0] ev;
    logic       eb, ed;
  } vec_t;

  typedef struct {
    logic [7:0] v;
    logic       b, d, z;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  descontador_timer #(.WIDTH(8)) dut0 (
    .clk(clk), .rst(rst_a[0]), .load(load_a[0]), .load_value(lv_a[0]),
    .start(start_a[0]), .minus(minus_a[0]), .pause(pause_a[0]),
    .auto_reload(ar_a[0]), .value(value_a[0]), .busy(busy_a[0]),
    .zero(zero_a[0]), .done(done_a[0]));

  descontador_timer #(.WIDTH(8), .MINUS_VALUE(3), .PRESCALE(2)) dut1 (
    .clk(clk), .rst(rst_a[1]), .load(load_a[1]), .load_value(lv_a[1]),
    .start(start_a[1]), .minus(minus_a[1]), .pause(pause_a[1]),
    .auto_reload(ar_a[1]), .value(value_a[1]), .busy(busy_a[1]),
    .zero(zero_a[1]), .done(done_a[1]));

  descontador_timer #(.WIDTH(8), .POS_EDGE(0)) dut2 (
    .clk(clk), .rst(rst_a[2]), .load(load_a[2]), .load_value(lv_a[2]),
    .start(start_a[2]), .minus(minus_a[2]), .pause(pause_a[2]),
    .auto_reload(ar_a[2]), .value(value_a[2]), .busy(busy_a[2]),
    .zero(zero_a[2]), .done(done_a[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(input int d, input bit r, input bit ld, input int lv,
                              input bit st, input bit mi, input bit pa, input bit ar,
                              input int ev, input bit eb, input bit ed);
    vec_t v;
    v.d = d; v.rst = r; v.load = ld; v.lv = 8'(lv);
    v.start = st; v.minus = mi; v.pause = pa; v.ar = ar;
    v.ev = 8'(ev); v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", nm, idx, act, exp);
    end
  endtask

  // Drive one vector (at a drive point), then check after the DUT's active edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    rst_a[v.d] = v.rst;   load_a[v.d] = v.load;   lv_a[v.d] = v.lv;
    start_a[v.d] = v.start; minus_a[v.d] = v.minus; pause_a[v.d] = v.pause;
    ar_a[v.d] = v.ar;
    e.v = v.ev; e.b = v.eb; e.d = v.ed; e.z = (v.ev == 8'd0);
    sb.push_back(e);
    if (v.d == 2) @(negedge clk); else @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("value", idx, value_a[v.d], g.v);
    chk("busy",  idx, {7'd0, busy_a[v.d]}, {7'd0, g.b});
    chk("done",  idx, {7'd0, done_a[v.d]}, {7'd0, g.d});
    chk("zero",  idx, {7'd0, zero_a[v.d]}, {7'd0, g.z});
    $display("vec %0d dut%0d: value=%0d busy=%0d done=%0d zero=%0d", idx, v.d,
             value_a[v.d], busy_a[v.d], done_a[v.d], zero_a[v.d]);
    if (v.d == 2) begin
      @(posedge clk);
      #2;
    end else begin
      #1;
    end
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1; load_a[i] = 1'b0; lv_a[i] = 8'd0; start_a[i] = 1'b0;
      minus_a[i] = 1'b0; pause_a[i] = 1'b0; ar_a[i] = 1'b0;
    end

    //   d  rst ld lv st mi pa ar  ev eb ed
    // Basic countdown
    add(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 0, 1, 5, 0, 0, 0, 0,  5, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  5, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  4, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  2, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0);
    // Pause and gaps
    add(0, 0, 1, 4, 0, 0, 0, 0,  4, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  4, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0,  3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0,  3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0,  3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  3, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  3, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  2, 1, 0);
    // Priority and abort
    add(0, 0, 1, 8, 0, 0, 0, 0,  8, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  8, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  7, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  6, 1, 0);
    add(0, 0, 1, 9, 1, 1, 0, 0,  9, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  9, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    // Auto-reload
    add(0, 0, 1, 2, 0, 0, 0, 1,  2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1,  2, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1,  2, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1,  2, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1,  1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1,  2, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1);
    // Reset mid-operation
    add(0, 0, 1, 5, 0, 0, 0, 0,  5, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  5, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  4, 1, 0);
    add(0, 1, 1, 7, 0, 1, 0, 0,  0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0);
    // Saturation and prescaler (MINUS_VALUE=3, PRESCALE=2)
    add(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(1, 0, 1, 7, 0, 0, 0, 0,  7, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0,  7, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  7, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  4, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  4, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0);
    add(1, 0, 1, 7, 0, 0, 0, 0,  7, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0,  7, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  7, 1, 0);
    add(1, 0, 1, 7, 0, 0, 0, 0,  7, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0,  7, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  7, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0,  7, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  7, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  4, 1, 0);
    // Basic countdown on the negedge-clocked instance
    add(2, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(2, 0, 1, 5, 0, 0, 0, 0,  5, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0, 0,  5, 1, 0);
    add(2, 0, 0, 0, 0, 1, 0, 0,  4, 1, 0);
    add(2, 0, 0, 0, 0, 1, 0, 0,  3, 1, 0);
    add(2, 0, 0, 0, 0, 1, 0, 0,  2, 1, 0);
    add(2, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0);
    add(2, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1);
    add(2, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0);

    @(posedge clk);
    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Negedge instance: a load driven after a rising edge is not visible
    // until the following falling edge.
    minus_a[2] = 1'b0; lv_a[2] = 8'd3; load_a[2] = 1'b1;
    #2;
    chk("neg_before_fall", 1000, value_a[2], 8'd0);
    $display("seq neg_before_fall: value=%0d", value_a[2]);
    @(negedge clk);
    #1;
    chk("neg_after_fall", 1001, value_a[2], 8'd3);
    $display("seq neg_after_fall: value=%0d", value_a[2]);
    load_a[2] = 1'b0;
    @(posedge clk);
    #2;

    // Default instance: expiry with minus held produces exactly one done pulse.
    rst_a[0] = 1'b0; pause_a[0] = 1'b0; ar_a[0] = 1'b0; start_a[0] = 1'b0;
    minus_a[0] = 1'b0; lv_a[0] = 8'd1; load_a[0] = 1'b1;
    @(posedge clk); #2;
    load_a[0] = 1'b0; start_a[0] = 1'b1;
    @(posedge clk); #2;
    start_a[0] = 1'b0; minus_a[0] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done_a[0] === 1'b1) pulses++;
    end
    chk("done_pulse_count", 1002, 8'(pulses), 8'd1);
    chk("busy_after_expiry", 1003, {7'd0, busy_a[0]}, 8'd0);
    $display("seq single_done: pulses=%0d busy=%0d", pulses, busy_a[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/descontador_timer.md
Name: descontador_timer

Overview:
- Programmable down-counter/timer: the consuming counterpart to the team's up-accumulators.
- Loads a count, then decrements it by a fixed step on qualified strobes (through a prescaler) until it reaches zero, then signals completion.
- Optional auto-reload.
- Used in retro_paint for frame/hold timing, column countdowns and blink periods, driven by controller FSMs through a load/start/done handshake.

Parameters:
- WIDTH, 8: width of count value and load_value.
- RST_VALUE, 0: value (and reload register) after reset.
- MINUS_VALUE, 1: decrement step per prescaled tick; must be ≥1 and < 2^WIDTH.
- PRESCALE, 1: qualified minus strobes per decrement; must be ≥1. 1 = every strobe decrements.
- POS_EDGE, 1: 1 = all state updates on posedge clk; 0 = on negedge clk.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- load  input  1  capture load_value into count and reload register.
- load_value  input  WIDTH  value to load.
- start  input  1  begin counting (pulse).
- minus  input  1  decrement strobe / enable; qualified per cycle.
- pause  input  1  level; freezes counting while high.
- auto_reload  input  1  level; on reaching zero, reload and continue.
- value  output  WIDTH  current count.
- busy  output  1  high in RUN or PAUSE.
- zero  output  1  value == 0 (combinational from value).
- done  output  1  one-cycle pulse when the count reaches zero or a start is issued with value 0.

Behaviour:
- Clocking: single clock edge selected by POS_EDGE. rst is sampled on that same edge and is synchronous, active-high.
- Reset:
  - value = RST_VALUE, reload register = RST_VALUE, prescaler = 0.
  - state = IDLE, busy = 0, done = 0.
  - rst overrides every other input in the same cycle.
- States: IDLE, RUN, PAUSE, DONE.
  - busy = 1 in RUN and PAUSE only.
- Input priority per cycle: rst > load > start > pause > minus.
- load, in any state:
  - value = load_value, reload register = load_value, prescaler = 0.
  - Next state IDLE. done stays 0.
  - An in-progress countdown is aborted silently.
- start in IDLE or DONE:
  - If value != 0: next state RUN, prescaler = 0.
  - If value == 0: done pulses the next cycle and state goes to DONE; no RUN entry.
- start in RUN or PAUSE: ignored.
- RUN with pause = 1: next state PAUSE; prescaler and value hold, and minus is ignored that cycle.
- PAUSE with pause = 0: next state RUN; counting resumes on the following minus.
- RUN with minus = 1 and pause = 0:
  - If prescaler < PRESCALE-1: prescaler += 1.
  - Otherwise prescaler = 0 and a decrement occurs.
- Decrement arithmetic is saturating:
  - If value > MINUS_VALUE: value -= MINUS_VALUE.
  - Otherwise the count has expired: value becomes 0 and zero is reached (no wrap-around).
- Zero reached, auto_reload sampled in the same cycle:
  - auto_reload = 1: value = reload register (not 0), stay in RUN, done pulses for 1 cycle.
  - If the reload register is 0 in that case: value = 0, go to DONE, done pulses once.
  - auto_reload = 0: value = 0, next state DONE, done pulses for 1 cycle, busy drops on that same edge.
- DONE: holds value 0 until load or start. done is never asserted for more than one cycle per expiry.
- Latency (PRESCALE = 1, MINUS_VALUE = 1): after start with value N, N qualified minus cycles bring value to 0. done is high in the cycle after the edge that registers the final decrement.
- Outputs are registered, except zero, which is combinational from value. done is registered.

Test Plan:
- Basic countdown:
  - Stimulus: rst, then load 5, start, minus held high.
  - Required: value 5→4→3→2→1→0 on consecutive edges; done is a single 1-cycle pulse on expiry; busy 1 → 0; state DONE; zero = 1.
- Saturation and prescaler:
  - Stimulus: MINUS_VALUE = 3, PRESCALE = 2, load 7, start, minus high.
  - Required: value 7→4 after 2 strobes, →1 after 4, →0 after 6; no wrap to 254; one done pulse.
- Auto-reload:
  - Stimulus: auto_reload = 1, load 2, start, minus high for 8 cycles.
  - Required: value 2,1,2,1,…; done pulses every 2nd decrement; busy stays 1.
- Pause and gaps:
  - Stimulus: load 4, start; minus high; pause high for 3 cycles after the first decrement; also a gap with minus low.
  - Required: value frozen at 3 throughout pause and the gap; resumes 3→2 after pause falls.
- Priority and abort:
  - Stimulus: mid-RUN at value 6, assert load(9) and start together.
  - Required: value = 9, state IDLE, no done. start with value 0 → done pulse, no busy.
- Reset mid-operation:
  - Stimulus: assert rst mid-RUN together with minus and load.
  - Required: value = RST_VALUE, busy = 0, done = 0 next edge. Repeat the basic countdown with POS_EDGE = 0 and check updates land on negedge.
